// File: rtl/ks_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : ks_pipe_adder
//  Purpose  : Parametrised, pipelined Kogge-Stone adder/subtractor with
//             carry-in modes, status flags, a pass-through tag and a
//             valid/ready handshake with backpressure.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  operand/result width, power of two, 4..32
//    LPS    prefix levels per pipeline stage, 1..log2(WIDTH)
//    TAG_W  sideband tag width, >= 1
//  Ports
//    clk, rst            clock (rising edge), synchronous active-high reset
//    in_valid/in_ready   operand beat handshake
//    in_a, in_b          operands
//    in_cin              carry/borrow-in (ops 01 and 11)
//    in_op               00 a+b, 01 a+b+cin, 10 a-b, 11 a+~b+cin
//    in_tag              sideband tag, returned unchanged in out_tag
//    out_valid/out_ready result beat handshake
//    out_sum             result (modulo 2^WIDTH, or saturated)
//    out_cout            carry out of MSB (subtract: 1 = no borrow)
//    out_ovf             signed overflow of the raw result
//    out_zero            out_sum == 0 (after saturation, if enabled)
//    out_tag             tag of this result
//  Build option
//    KS_SAT_EN           when defined, out_sum saturates on signed overflow
//  Latency: 1 + ceil(log2(WIDTH)/LPS) register banks from input to output.
// ============================================================================
module ks_pipe_adder #(
   parameter int WIDTH = 8,
   parameter int LPS   = 1,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NLEV = $clog2(WIDTH);

   // Whole pipe advances together; bubbles are not collapsed.
   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   always_comb begin
      w_b_eff = in_op[1] ? ~in_b : in_b;
      case (in_op)
         2'b00:   w_c0 = 1'b0;
         2'b10:   w_c0 = 1'b1;
         default: w_c0 = in_cin;
      endcase
   end

   // Level 0 is the operand bank; levels 1..NLEV are prefix levels with
   // span 2^(l-1). A level is registered every LPS levels and at the last one.
   for (genvar l = 0; l <= NLEV; l++) begin : g_lvl
      logic [WIDTH-1:0] w_g;   // group generate, bit i covers [i:-1]
      logic [WIDTH-1:0] w_h;   // half-sum a ^ b_eff, carried to the end
      logic             w_c;   // carry-in, needed for sum bit 0
      logic             w_v;
      logic [TAG_W-1:0] w_t;

      if (l == 0) begin : g_src
         logic [WIDTH-1:0] r_g;
         logic [WIDTH-1:0] r_h;
         logic             r_c;
         logic             r_v;
         logic [TAG_W-1:0] r_t;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_g <= '0;
               r_h <= '0;
               r_c <= 1'b0;
               r_v <= 1'b0;
               r_t <= '0;
            end else if (w_adv) begin
               r_g <= in_a & w_b_eff;
               r_h <= in_a ^ w_b_eff;
               r_c <= w_c0;
               r_v <= in_valid;
               r_t <= in_tag;
            end
         end

         // Carry-in folded into bit 0 so the prefix tree yields carries
         // directly: after the last level, w_g[i] is the carry into bit i+1.
         assign w_g = {r_g[WIDTH-1:1], r_g[0] | (r_h[0] & r_c)};
         assign w_h = r_h;
         assign w_c = r_c;
         assign w_v = r_v;
         assign w_t = r_t;
      end else begin : g_pfx
         localparam int SPAN = 1 << (l - 1);
         localparam bit BANK = ((l % LPS) == 0) || (l == NLEV);
         logic [WIDTH-1:0] w_ng;

         assign w_ng = g_lvl[l-1].w_g |
                       (g_lvl[l-1].g_p.w_p &
                        {g_lvl[l-1].w_g[WIDTH-1-SPAN:0], {SPAN{1'b0}}});

         if (BANK) begin : g_bank
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_h;
            logic             r_c;
            logic             r_v;
            logic [TAG_W-1:0] r_t;

            always_ff @(posedge clk) begin
               if (rst) begin
                  r_g <= '0;
                  r_h <= '0;
                  r_c <= 1'b0;
                  r_v <= 1'b0;
                  r_t <= '0;
               end else if (w_adv) begin
                  r_g <= w_ng;
                  r_h <= g_lvl[l-1].w_h;
                  r_c <= g_lvl[l-1].w_c;
                  r_v <= g_lvl[l-1].w_v;
                  r_t <= g_lvl[l-1].w_t;
               end
            end

            assign w_g = r_g;
            assign w_h = r_h;
            assign w_c = r_c;
            assign w_v = r_v;
            assign w_t = r_t;
         end else begin : g_thru
            assign w_g = w_ng;
            assign w_h = g_lvl[l-1].w_h;
            assign w_c = g_lvl[l-1].w_c;
            assign w_v = g_lvl[l-1].w_v;
            assign w_t = g_lvl[l-1].w_t;
         end
      end

      // Group propagate is only consumed by the following level, so the
      // last level has none.
      if (l < NLEV) begin : g_p
         logic [WIDTH-1:0] w_p;

         if (l == 0) begin : g_src
            assign w_p = w_h;
         end else begin : g_pfx
            localparam int SPAN = 1 << (l - 1);
            localparam bit BANK = ((l % LPS) == 0);
            logic [WIDTH-1:0] w_np;

            // Low SPAN bits are ANDed with 1 so they pass unchanged.
            assign w_np = g_lvl[l-1].g_p.w_p &
                          {g_lvl[l-1].g_p.w_p[WIDTH-1-SPAN:0], {SPAN{1'b1}}};

            if (BANK) begin : g_bank
               logic [WIDTH-1:0] r_p;
               always_ff @(posedge clk) begin
                  if (rst) begin
                     r_p <= '0;
                  end else if (w_adv) begin
                     r_p <= w_np;
                  end
               end
               assign w_p = r_p;
            end else begin : g_thru
               assign w_p = w_np;
            end
         end
      end
   end

   // Output stage, combinational from the last bank.
   logic [WIDTH-1:0] w_gf;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   assign w_gf   = g_lvl[NLEV].w_g;
   assign w_raw  = g_lvl[NLEV].w_h ^ {w_gf[WIDTH-2:0], g_lvl[NLEV].w_c};
   assign w_cout = w_gf[WIDTH-1];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign w_ovf  = w_gf[WIDTH-1] ^ w_gf[WIDTH-2];

`ifdef KS_SAT_EN
   // On overflow both operands share a sign, and cout equals that sign.
   assign w_sum = w_ovf ? {w_cout, {(WIDTH-1){~w_cout}}} : w_raw;
`else
   assign w_sum = w_raw;
`endif

   assign out_valid = g_lvl[NLEV].w_v;
   assign w_adv     = ~out_valid | out_ready;
   assign in_ready  = w_adv;
   assign out_sum   = w_sum;
   assign out_cout  = w_cout;
   assign out_ovf   = w_ovf;
   assign out_zero  = (w_sum == '0);
   assign out_tag   = g_lvl[NLEV].w_t;

endmodule
`default_nettype wire

// File: tb/tb_ks_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ks_pipe_adder
//  Purpose  : Self-checking bench for ks_pipe_adder. Instance d8 is
//             WIDTH=8/LPS=1 (directed tests), instance d16 is
//             WIDTH=16/LPS=2 (randomised handshake traffic vs. a model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ks_pipe_adder;

   localparam int TW    = 4;
   localparam int LAT8  = 4;
   localparam int NRAND = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          d8_in_valid, d8_in_ready, d8_in_cin, d8_out_valid, d8_out_ready;
   logic          d8_out_cout, d8_out_ovf, d8_out_zero;
   logic [7:0]    d8_in_a, d8_in_b, d8_out_sum;
   logic [1:0]    d8_in_op;
   logic [TW-1:0] d8_in_tag, d8_out_tag;

   logic          d16_in_valid, d16_in_ready, d16_in_cin, d16_out_valid, d16_out_ready;
   logic          d16_out_cout, d16_out_ovf, d16_out_zero;
   logic [15:0]   d16_in_a, d16_in_b, d16_out_sum;
   logic [1:0]    d16_in_op;
   logic [TW-1:0] d16_in_tag, d16_out_tag;

   ks_pipe_adder #(.WIDTH(8), .LPS(1), .TAG_W(TW)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(d8_in_valid), .in_ready(d8_in_ready),
      .in_a(d8_in_a), .in_b(d8_in_b), .in_cin(d8_in_cin), .in_op(d8_in_op), .in_tag(d8_in_tag),
      .out_valid(d8_out_valid), .out_ready(d8_out_ready),
      .out_sum(d8_out_sum), .out_cout(d8_out_cout), .out_ovf(d8_out_ovf),
      .out_zero(d8_out_zero), .out_tag(d8_out_tag)
   );

   ks_pipe_adder #(.WIDTH(16), .LPS(2), .TAG_W(TW)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(d16_in_valid), .in_ready(d16_in_ready),
      .in_a(d16_in_a), .in_b(d16_in_b), .in_cin(d16_in_cin), .in_op(d16_in_op), .in_tag(d16_in_tag),
      .out_valid(d16_out_valid), .out_ready(d16_out_ready),
      .out_sum(d16_out_sum), .out_cout(d16_out_cout), .out_ovf(d16_out_ovf),
      .out_zero(d16_out_zero), .out_tag(d16_out_tag)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0]   sum;
      logic          cout;
      logic          ovf;
      logic          zero;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];

   // Reference: plain integer arithmetic on w-bit values.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [1:0] op, input logic [TW-1:0] tag);
      longint unsigned mask, half, av, bv, c0, full;
      exp_t r;
      mask = (64'd1 << w) - 64'd1;
      half = 64'd1 << (w - 1);
      av   = {32'd0, a} & mask;
      bv   = {32'd0, b} & mask;
      if (op[1]) bv = mask - bv;
      if (op == 2'b00)      c0 = 0;
      else if (op == 2'b10) c0 = 1;
      else                  c0 = {63'd0, cin};
      full   = av + bv + c0;
      r.sum  = 32'(full & mask);
      r.cout = ((full >> w) & 64'd1) != 0;
      r.ovf  = ((av & half) == (bv & half)) && ((full & half) != (av & half));
`ifdef KS_SAT_EN
      if (r.ovf) r.sum = ((av & half) != 0) ? 32'(half) : 32'(half - 1);
`endif
      r.zero = (r.sum == 32'd0);
      r.tag  = tag;
      return r;
   endfunction

   function automatic exp_t obs8();
      exp_t r;
      r.sum = {24'd0, d8_out_sum}; r.cout = d8_out_cout; r.ovf = d8_out_ovf;
      r.zero = d8_out_zero; r.tag = d8_out_tag;
      return r;
   endfunction

   function automatic exp_t obs16();
      exp_t r;
      r.sum = {16'd0, d16_out_sum}; r.cout = d16_out_cout; r.ovf = d16_out_ovf;
      r.zero = d16_out_zero; r.tag = d16_out_tag;
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, req);
      end
   endtask

   // Present one beat to the idle d8 pipe and wait (bounded) for its result.
   // Latency counts cycles from the cycle the beat is presented.
   task automatic beat8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [1:0] op, input logic [TW-1:0] tag);
      exp_t e;
      int   lat;
      e = model(8, {24'd0, a}, {24'd0, b}, cin, op, tag);
      d8_in_a = a; d8_in_b = b; d8_in_cin = cin; d8_in_op = op; d8_in_tag = tag;
      d8_in_valid = 1'b1;
      @(posedge clk); #1;
      d8_in_valid = 1'b0;
      lat = 1;
      while (!d8_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({nm, " latency"}, 64'(lat), 64'(LAT8));
      check({nm, " sum"},  64'(d8_out_sum),  64'(e.sum));
      check({nm, " cout"}, 64'(d8_out_cout), 64'(e.cout));
      check({nm, " ovf"},  64'(d8_out_ovf),  64'(e.ovf));
      check({nm, " zero"}, 64'(d8_out_zero), 64'(e.zero));
      check({nm, " tag"},  64'(d8_out_tag),  64'(e.tag));
      @(posedge clk); #1;
   endtask

   initial begin
      int   sent, got, cyc, stale;
      logic prev_stall;
      exp_t e, snap;

      // ---- reset, with in_valid asserted (must be ignored) ----
      rst = 1'b1;
      d8_in_valid = 1'b1; d8_in_a = 8'h12; d8_in_b = 8'h34; d8_in_cin = 1'b0;
      d8_in_op = 2'b00; d8_in_tag = 4'h9; d8_out_ready = 1'b1;
      d16_in_valid = 1'b0; d16_in_a = '0; d16_in_b = '0; d16_in_cin = 1'b0;
      d16_in_op = 2'b00; d16_in_tag = '0; d16_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      d8_in_valid = 1'b0;
      check("reset out_valid", 64'(d8_out_valid), 64'(0));
      check("reset in_ready",  64'(d8_in_ready),  64'(1));
      check("reset sum",       64'(d8_out_sum),   64'(0));
      check("reset tag",       64'(d8_out_tag),   64'(0));
      check("reset cout",      64'(d8_out_cout),  64'(0));
      check("reset ovf",       64'(d8_out_ovf),   64'(0));
      check("reset zero",      64'(d8_out_zero),  64'(1));
      check("reset d16 valid", 64'(d16_out_valid), 64'(0));
      check("reset d16 zero",  64'(d16_out_zero),  64'(1));
      stale = 0;
      for (int i = 0; i < LAT8 + 2; i++) begin
         @(negedge clk);
         if (d8_out_valid) stale++;
         @(posedge clk); #1;
      end
      check("reset ignored in_valid", 64'(stale), 64'(0));

      // ---- directed vectors ----
      beat8("ff+01",      8'hFF, 8'h01, 1'b0, 2'b00, 4'd3);
      beat8("05-07",      8'h05, 8'h07, 1'b0, 2'b10, 4'd5);
      beat8("05+~07+0",   8'h05, 8'h07, 1'b0, 2'b11, 4'd6);
      beat8("05+~07+1",   8'h05, 8'h07, 1'b1, 2'b11, 4'd7);
      beat8("40+3f+cin",  8'h40, 8'h3F, 1'b1, 2'b01, 4'd8);
      beat8("7f+01",      8'h7F, 8'h01, 1'b0, 2'b00, 4'd10);
      beat8("80+ff",      8'h80, 8'hFF, 1'b0, 2'b00, 4'd11);
      beat8("80-01",      8'h80, 8'h01, 1'b0, 2'b10, 4'd12);

      // ---- 16 back-to-back beats with a 3-cycle output stall ----
      sent = 0; got = 0; cyc = 0; snap = '0;
      while ((sent < 16 || got < 16) && cyc < 200) begin
         d8_in_valid = (sent < 16);
         d8_in_a = 8'($urandom); d8_in_b = 8'($urandom);
         d8_in_cin = 1'($urandom); d8_in_op = 2'($urandom);
         d8_in_tag = TW'(sent);
         d8_out_ready = !(cyc >= 6 && cyc < 9);
         @(negedge clk);
         if (!d8_out_ready) begin
            check("stream stall in_ready", 64'(d8_in_ready), 64'(0));
            check("stream stall out_valid", 64'(d8_out_valid), 64'(1));
            if (cyc == 6) snap = obs8();
            else check("stream stall hold", 64'(obs8()), 64'(snap));
         end
         if (d8_in_valid && d8_in_ready) begin
            q8.push_back(model(8, {24'd0, d8_in_a}, {24'd0, d8_in_b}, d8_in_cin, d8_in_op, d8_in_tag));
            sent++;
         end
         if (d8_out_valid && d8_out_ready) begin
            e = (q8.size() > 0) ? q8.pop_front() : '1;
            check("stream result", 64'(obs8()), 64'(e));
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      d8_in_valid = 1'b0; d8_out_ready = 1'b1;
      check("stream count", 64'(got), 64'(16));
      check("stream cycles", 64'(cyc), 64'(16 + (LAT8 - 1) + 3 + 1));

      // ---- reset while three beats are in flight ----
      for (int i = 0; i < 3; i++) begin
         d8_in_valid = 1'b1;
         d8_in_a = 8'($urandom); d8_in_b = 8'($urandom);
         d8_in_op = 2'b00; d8_in_tag = TW'(i + 1);
         @(posedge clk); #1;
      end
      d8_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst out_valid", 64'(d8_out_valid), 64'(0));
      check("midrst in_ready",  64'(d8_in_ready),  64'(1));
      check("midrst tag",       64'(d8_out_tag),   64'(0));
      stale = 0;
      for (int i = 0; i < LAT8 + 2; i++) begin
         @(negedge clk);
         if (d8_out_valid) stale++;
         @(posedge clk); #1;
      end
      check("midrst stale", 64'(stale), 64'(0));
      beat8("post-reset", 8'h21, 8'h0E, 1'b0, 2'b00, 4'd13);

      // ---- W=16/LPS=2 random traffic vs. model ----
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
      while (got < NRAND && cyc < 20000) begin
         d16_in_valid = (sent < NRAND) && ($urandom_range(0, 9) < 7);
         d16_in_a = 16'($urandom); d16_in_b = 16'($urandom);
         d16_in_cin = 1'($urandom); d16_in_op = 2'($urandom);
         d16_in_tag = TW'($urandom);
         d16_out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (prev_stall)
            check("rand stall hold", 64'({d16_out_valid, obs16()}), 64'({1'b1, snap}));
         if (d16_in_valid && d16_in_ready) begin
            q16.push_back(model(16, {16'd0, d16_in_a}, {16'd0, d16_in_b}, d16_in_cin, d16_in_op, d16_in_tag));
            sent++;
         end
         if (d16_out_valid && d16_out_ready) begin
            e = (q16.size() > 0) ? q16.pop_front() : '1;
            check("rand result", 64'(obs16()), 64'(e));
            got++;
         end
         prev_stall = d16_out_valid && !d16_out_ready;
         snap = obs16();
         @(posedge clk); #1;
         cyc++;
      end
      d16_in_valid = 1'b0; d16_out_ready = 1'b1;
      check("rand count", 64'(got), 64'(NRAND));
      check("rand leftover", 64'(q16.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
